knn_query_sequencer: RTL and testbench
======================================

# knn_query_sequencer

Upstream front-end for the kNN classifier. It buffers incoming test samples in a small FIFO and issues them one at a time over the classifier's start/done handshake. It captures each predicted class and presents it on a valid/ready result port, tagged with a sequence number. A watchdog turns a hung classifier into a flagged result and a halt.

## Interface
Parameters:
- DATA_WIDTH, 8: bits per feature
- NUM_FEATURES, 2: features per sample; sample width W = DATA_WIDTH*NUM_FEATURES
- FIFO_DEPTH, 4: query FIFO entries; power of two, ≥2
- K_DEFAULT, 3: k substituted when in_k == 0
- TIMEOUT_CYCLES, 4095: maximum cycles spent in WAIT_DONE; must be < 65536

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous assert, active-low (0 = reset)
- in_valid  in  1  query offered
- in_ready  out  1  FIFO can accept a query
- in_data  in  W  test sample, feature 1 in MSBs
- in_k  in  DATA_WIDTH  requested k
- knn_start  out  1  classifier start, level-held
- knn_test_data  out  W  sample for the classifier
- knn_k_value  out  DATA_WIDTH  k for the classifier
- knn_done  in  1  classifier done
- knn_class  in  1  classifier predicted_class
- res_valid  out  1  result available
- res_ready  in  1  result accepted
- res_class  out  1  predicted class (0 when res_timeout = 1)
- res_tag  out  8  sequence number of the query, 0-based
- res_timeout  out  1  result produced by the watchdog
- busy  out  1  FSM not in IDLE, or FIFO not empty
- fifo_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

## Operation
- FIFO
  - Entry is {k, in_data}. The push stores k as K_DEFAULT if in_k == 0, otherwise in_k.
  - in_ready = !halted && fifo_count < FIFO_DEPTH. It depends on registered state only, never on in_valid.
  - Push on in_valid && in_ready.
  - When full, a same-cycle pop does not open a slot; in_ready stays 0 that cycle.
  - Simultaneous push and pop: count unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, WAIT_DONE, RELEASE, OUTPUT, HALT.
- IDLE
  - If FIFO non-empty: pop, load knn_test_data and knn_k_value from the head, set knn_start <= 1, clear the timer, go to WAIT_DONE.
  - res_valid is always 0 in IDLE, so the result slot is free.
- WAIT_DONE
  - On knn_done == 1: res_class <= knn_class, res_timeout <= 0, knn_start <= 0, go to RELEASE.
  - Otherwise, when timer == TIMEOUT_CYCLES-1: res_class <= 0, res_timeout <= 1, knn_start <= 0, go to RELEASE.
  - Otherwise timer increments (16-bit).
- RELEASE
  - Wait for knn_done == 0, which confirms the classifier has returned to idle.
  - Then res_valid <= 1 and go to OUTPUT.
  - After a timeout knn_done is normally already 0, so this exit is immediate.
- OUTPUT
  - Hold res_valid, res_class, res_tag and res_timeout stable until res_ready.
  - On res_valid && res_ready: res_valid <= 0 and res_tag increments (wraps 255 -> 0).
  - Then go to HALT if res_timeout == 1, else to IDLE.
- HALT
  - Terminal until reset. in_ready = 0, no further issues, FIFO contents retained.
  - busy = 1. fifo_count still reflects the stored entries.
- knn_test_data and knn_k_value remain valid for the whole of WAIT_DONE.

## Timing
- Reset values: in_ready 0 during reset and 1 on the first cycle after release; knn_start 0; knn_test_data 0; knn_k_value 0; res_valid 0; res_class 0; res_tag 0; res_timeout 0; busy 0; fifo_count 0; FSM in IDLE; halted 0.
- All outputs are registered except in_ready and busy, which are decoded from registers.
- Issue latency with an empty FIFO:
  - Push in cycle 0, pop in cycle 1, knn_start = 1 from cycle 2.
- Completion latency:
  - knn_done first seen high in cycle N, so knn_start = 0 from N+1.
  - RELEASE sees knn_done low at cycle M ≥ N+1, so res_valid = 1 from M+1.
- Back-to-back:
  - The next issue occurs at the earliest in the cycle after the res handshake.
  - Minimum spacing between knn_start rising edges is 4 cycles plus classifier latency plus the res_ready stall.
- Reset mid-operation: all state clears immediately (asynchronous) and FIFO contents are discarded.

## Test plan
- Single query in_data={3,3}, in_k=3, driving a live classifier with reset tied to ~rst -> knn_start rises 2 cycles after push; result res_class=1, res_tag=0, res_timeout=0.
- Query {1,10} with in_k=0 -> knn_k_value=3 while issued; res_class=0.
- Push 6 queries back-to-back with res_ready=1 and FIFO_DEPTH=4 -> in_ready drops at count 4; all 6 results come out in order with tags 0..5 and no loss or duplication.
- Hold res_ready=0 for 50 cycles after the first result -> res_valid and res_class/res_tag stay stable; no second knn_start until the handshake.
- knn_done tied 0 with TIMEOUT_CYCLES=20 -> knn_start falls after 20 cycles in WAIT_DONE; result res_timeout=1, res_class=0; then HALT with in_ready=0 until reset.
- Assert rst=0 during WAIT_DONE with 2 entries queued -> all outputs return to their reset values immediately; fifo_count=0; a fresh query after release is processed with res_tag=0.

Source files
------------

// File: rtl/knn_query_sequencer.sv
// Query front-end for the kNN classifier: buffers samples in a FIFO, issues them over a
// level-held start/done handshake, and returns tagged results with a watchdog-driven halt.
module knn_query_sequencer #(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_FEATURES   = 2,
  parameter int FIFO_DEPTH     = 4,
  parameter int K_DEFAULT      = 3,
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [DATA_WIDTH*NUM_FEATURES-1:0]   in_data,
  input  logic [DATA_WIDTH-1:0]                in_k,
  output logic                                 knn_start,
  output logic [DATA_WIDTH*NUM_FEATURES-1:0]   knn_test_data,
  output logic [DATA_WIDTH-1:0]                knn_k_value,
  input  logic                                 knn_done,
  input  logic                                 knn_class,
  output logic                                 res_valid,
  input  logic                                 res_ready,
  output logic                                 res_class,
  output logic [7:0]                           res_tag,
  output logic                                 res_timeout,
  output logic                                 busy,
  output logic [$clog2(FIFO_DEPTH):0]          fifo_count
);

  localparam int W  = DATA_WIDTH * NUM_FEATURES;
  localparam int EW = DATA_WIDTH + W;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DONE,
    S_RELEASE,
    S_OUTPUT,
    S_HALT
  } state_t;

  state_t state_q, state_d;

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ready_en_q;

  logic                  knn_start_q, knn_start_d;
  logic [W-1:0]          test_data_q, test_data_d;
  logic [DATA_WIDTH-1:0] k_value_q, k_value_d;
  logic                  res_valid_q, res_valid_d;
  logic                  res_class_q, res_class_d;
  logic                  res_timeout_q, res_timeout_d;
  logic [7:0]            res_tag_q, res_tag_d;
  logic [15:0]           timer_q, timer_d;

  logic                  push;
  logic                  pop;
  logic                  halted;
  logic [DATA_WIDTH-1:0] k_eff;
  logic [EW-1:0]         head;

  // Handshakes: a query moves on in_valid && in_ready, a result on res_valid && res_ready.
  // in_ready is built from registered state only, so it never depends on in_valid.
  assign halted   = (state_q == S_HALT);
  assign in_ready = ready_en_q && !halted && (count_q < CW'(FIFO_DEPTH));
  assign push     = in_valid && in_ready;
  assign k_eff    = (in_k == '0) ? DATA_WIDTH'(K_DEFAULT) : in_k;
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: resetting the pointers discards the contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {k_eff, in_data};
  end

  always_comb begin
    state_d       = state_q;
    knn_start_d   = knn_start_q;
    test_data_d   = test_data_q;
    k_value_d     = k_value_q;
    res_valid_d   = res_valid_q;
    res_class_d   = res_class_q;
    res_timeout_d = res_timeout_q;
    res_tag_d     = res_tag_q;
    timer_d       = timer_q;
    pop           = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop         = 1'b1;
          test_data_d = head[W-1:0];
          k_value_d   = head[EW-1:W];
          knn_start_d = 1'b1;
          timer_d     = '0;
          state_d     = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (knn_done) begin
          res_class_d   = knn_class;
          res_timeout_d = 1'b0;
          knn_start_d   = 1'b0;
          state_d       = S_RELEASE;
        end else if (timer_q == TIMER_LAST) begin
          res_class_d   = 1'b0;
          res_timeout_d = 1'b1;
          knn_start_d   = 1'b0;
          state_d       = S_RELEASE;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      S_RELEASE: begin
        // Only present the result once the classifier has dropped done.
        if (!knn_done) begin
          res_valid_d = 1'b1;
          state_d     = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          res_tag_d   = res_tag_q + 8'd1;
          state_d     = res_timeout_q ? S_HALT : S_IDLE;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      ready_en_q    <= 1'b0;
      knn_start_q   <= 1'b0;
      test_data_q   <= '0;
      k_value_q     <= '0;
      res_valid_q   <= 1'b0;
      res_class_q   <= 1'b0;
      res_timeout_q <= 1'b0;
      res_tag_q     <= '0;
      timer_q       <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      ready_en_q    <= 1'b1;
      knn_start_q   <= knn_start_d;
      test_data_q   <= test_data_d;
      k_value_q     <= k_value_d;
      res_valid_q   <= res_valid_d;
      res_class_q   <= res_class_d;
      res_timeout_q <= res_timeout_d;
      res_tag_q     <= res_tag_d;
      timer_q       <= timer_d;
    end
  end

  assign knn_start     = knn_start_q;
  assign knn_test_data = test_data_q;
  assign knn_k_value   = k_value_q;
  assign res_valid     = res_valid_q;
  assign res_class     = res_class_q;
  assign res_timeout   = res_timeout_q;
  assign res_tag       = res_tag_q;
  assign fifo_count    = count_q;
  assign busy          = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_knn_query_sequencer.sv
// Bench for knn_query_sequencer: mock classifier, queue-based reference model and
// a cycle monitor, driven by a vector table, hand sequences and random traffic.
module tb_knn_query_sequencer;

  localparam int DW    = 8;
  localparam int NF    = 2;
  localparam int W     = DW * NF;
  localparam int EW    = DW + W;
  localparam int DEPTH = 4;
  localparam int K_DEF = 3;
  localparam int TMO   = 20;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [DW-1:0] in_k;
  logic          knn_start;
  logic [W-1:0]  knn_test_data;
  logic [DW-1:0] knn_k_value;
  logic          knn_done;
  logic          knn_class;
  logic          res_valid;
  logic          res_ready;
  logic          res_class;
  logic [7:0]    res_tag;
  logic          res_timeout;
  logic          busy;
  logic [CW-1:0] fifo_count;

  knn_query_sequencer #(
    .DATA_WIDTH(DW), .NUM_FEATURES(NF), .FIFO_DEPTH(DEPTH),
    .K_DEFAULT(K_DEF), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_k(in_k),
    .knn_start(knn_start), .knn_test_data(knn_test_data), .knn_k_value(knn_k_value),
    .knn_done(knn_done), .knn_class(knn_class),
    .res_valid(res_valid), .res_ready(res_ready), .res_class(res_class),
    .res_tag(res_tag), .res_timeout(res_timeout),
    .busy(busy), .fifo_count(fifo_count)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int tests_run;
  int tests_failed;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic ref_class(input logic [W-1:0] d);
    return d[W-1 -: DW] >= d[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] ref_k(input logic [DW-1:0] k);
    return (k == '0) ? DW'(K_DEF) : k;
  endfunction

  logic [EW-1:0] exp_q[$];   // queued queries {k, data}, in arrival order
  logic [1:0]    res_q[$];   // issued queries awaiting a result: {timeout, class}
  int            res_cnt;
  int            issue_cnt;
  logic          halted_m;

  // ---------------- mock classifier ----------------
  logic hang_mode;
  logic lat_random;
  int   cls_lat;
  int   rel_lat;
  int   cur_lat;
  int   cur_rel;
  int   resp_cnt;
  int   resp_phase;

  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      knn_done   = 1'b0;
      knn_class  = 1'b0;
      resp_cnt   = 0;
      resp_phase = 0;
    end else begin
      case (resp_phase)
        0: if (knn_start) begin
             cur_lat    = lat_random ? int'($urandom_range(0, 5)) : cls_lat;
             cur_rel    = lat_random ? int'($urandom_range(0, 3)) : rel_lat;
             resp_cnt   = 0;
             resp_phase = 1;
           end
        1: if (!knn_start) resp_phase = 0;
           else if (!hang_mode) begin
             if (resp_cnt >= cur_lat) begin
               knn_done   = 1'b1;
               knn_class  = ref_class(knn_test_data);
               resp_phase = 2;
             end else resp_cnt++;
           end
        2: if (!knn_start) begin
             resp_cnt   = 0;
             resp_phase = 3;
           end
        default: begin
          if (resp_cnt >= cur_rel) begin
            knn_done   = 1'b0;
            resp_phase = 0;
          end else resp_cnt++;
        end
      endcase
    end
  end

  // ---------------- result sink ----------------
  logic rr_random;
  logic rr_fixed;
  always @(negedge clk) res_ready = rr_random ? ($urandom_range(0, 3) != 0) : rr_fixed;

  // ---------------- monitor / scoreboard (samples 1 time unit before posedge) ----------------
  logic          mon_en;
  logic          p_start, p_done, p_rv, p_rr, in_rel, issue_hang;
  logic [9:0]    p_out;
  logic [EW-1:0] cur_issue;
  logic [1:0]    res_e;
  int            hi_cnt;

  always begin
    @(negedge clk); #4;
    if (mon_en && rst) begin
      if (knn_start && !p_start) begin
        if (exp_q.size() == 0) check("issue_without_query", 32'(exp_q.size()), 32'd1);
        else begin
          cur_issue  = exp_q.pop_front();
          issue_hang = hang_mode;
          res_q.push_back(hang_mode ? 2'b10 : {1'b0, ref_class(cur_issue[W-1:0])});
        end
        issue_cnt++;
        hi_cnt = 0;
      end
      if (knn_start) begin
        hi_cnt++;
        check("issue_payload", {8'd0, knn_k_value, knn_test_data}, {8'd0, cur_issue});
      end
      if (p_start && p_done) check("start_drop_after_done", knn_start, 1'b0);
      if (in_rel) begin
        check("res_valid_after_release", res_valid, !p_done);
        if (res_valid) in_rel = 1'b0;
      end
      if (p_start && !knn_start) begin
        if (issue_hang) check("timeout_len", hi_cnt, TMO);
        in_rel = 1'b1;
      end
      if (p_rv && !p_rr) begin
        check("hold_valid", res_valid, 1'b1);
        check("hold_result", {res_class, res_tag, res_timeout}, p_out);
      end
      if (res_valid) check("no_issue_while_output", knn_start, 1'b0);
      check("fifo_count", fifo_count, 32'(exp_q.size()));
      check("in_ready", in_ready, !halted_m && (exp_q.size() < DEPTH));
      check("busy", busy, (exp_q.size() != 0) || (res_q.size() != 0) || halted_m);
      if (res_valid && res_ready) begin
        if (res_q.size() == 0) check("result_without_issue", 32'(res_q.size()), 32'd1);
        else begin
          res_e = res_q.pop_front();
          check("res_class", res_class, res_e[0]);
          check("res_timeout", res_timeout, res_e[1]);
          check("res_tag", res_tag, 32'(8'(res_cnt)));
          if (res_e[1]) halted_m = 1'b1;
        end
        res_cnt++;
      end
      if (in_valid && in_ready) exp_q.push_back({ref_k(in_k), in_data});
      p_start = knn_start;
      p_done  = knn_done;
      p_rv    = res_valid;
      p_rr    = res_ready;
      p_out   = {res_class, res_tag, res_timeout};
    end else begin
      p_start = 1'b0;
      p_done  = 1'b0;
      p_rv    = 1'b0;
      p_rr    = 1'b0;
      in_rel  = 1'b0;
      hi_cnt  = 0;
    end
  end

  // ---------------- driver tasks (all return at the sample point) ----------------
  task automatic tick();
    @(negedge clk); #4;
  endtask

  task automatic push_query(input logic [W-1:0] d, input logic [DW-1:0] k);
    int waited;
    waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_k     = k;
    #4;
    while (!in_ready && waited < 500) begin
      tick();
      waited++;
    end
    check("push_accepted", in_ready, 1'b1);
  endtask

  task automatic idle_in();
    @(negedge clk);
    in_valid = 1'b0;
    #4;
  endtask

  task automatic wait_res_valid(input int budget);
    int n;
    n = 0;
    while (!res_valid && n < budget) begin
      tick();
      n++;
    end
    check("wait_res_valid", res_valid, 1'b1);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || res_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check("drain", 32'(exp_q.size() + res_q.size()), 32'd0);
    tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    mon_en   = 1'b0;
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_knn_start", knn_start, 1'b0);
    check("rst_test_data", knn_test_data, '0);
    check("rst_k_value", knn_k_value, '0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_class", res_class, 1'b0);
    check("rst_res_tag", res_tag, '0);
    check("rst_res_timeout", res_timeout, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_fifo_count", fifo_count, '0);
    exp_q.delete();
    res_q.delete();
    res_cnt   = 0;
    issue_cnt = 0;
    halted_m  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("release_in_ready", in_ready, 1'b1);
    check("release_busy", busy, 1'b0);
    @(negedge clk);
    mon_en = 1'b1;
    #4;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [W-1:0]  data;
    logic [DW-1:0] k_in;
    logic [DW-1:0] exp_k;
    logic          exp_class;
    logic [7:0]    exp_tag;
  } vec_t;

  localparam int NV = 5;
  vec_t vecs[NV];

  logic [9:0] cap;
  int         n_issue;
  int         n;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    in_k         = '0;
    rr_random    = 1'b0;
    rr_fixed     = 1'b1;
    hang_mode    = 1'b0;
    lat_random   = 1'b0;
    cls_lat      = 2;
    rel_lat      = 1;
    mon_en       = 1'b0;
    issue_hang   = 1'b0;
    cur_issue    = '0;

    vecs[0] = '{16'h0303, 8'd3,   8'd3,   1'b1, 8'd0};
    vecs[1] = '{16'h010A, 8'd0,   8'd3,   1'b0, 8'd1};
    vecs[2] = '{16'hC805, 8'd7,   8'd7,   1'b1, 8'd2};
    vecs[3] = '{16'h00FF, 8'd255, 8'd255, 1'b0, 8'd3};
    vecs[4] = '{16'h0909, 8'd0,   8'd3,   1'b1, 8'd4};

    do_reset();

    // Single queries: issue latency, k substitution, class and tag.
    for (int i = 0; i < NV; i++) begin
      push_query(vecs[i].data, vecs[i].k_in);
      idle_in();
      check("lat_cycle1_start", knn_start, 1'b0);
      check("lat_cycle1_count", fifo_count, 32'd1);
      tick();
      check("lat_cycle2_start", knn_start, 1'b1);
      check("vec_k_value", knn_k_value, vecs[i].exp_k);
      check("vec_test_data", knn_test_data, vecs[i].data);
      wait_res_valid(200);
      check("vec_class", res_class, vecs[i].exp_class);
      check("vec_tag", res_tag, vecs[i].exp_tag);
      check("vec_timeout", res_timeout, 1'b0);
      wait_drain(100);
    end

    // Result back-pressure: hold res_ready low for 50 cycles.
    rr_fixed = 1'b0;
    push_query(16'h0A02, 8'd5);
    push_query(16'h0205, 8'd0);
    idle_in();
    wait_res_valid(200);
    cap     = {res_class, res_tag, res_timeout};
    n_issue = issue_cnt;
    repeat (50) tick();
    check("stall_valid", res_valid, 1'b1);
    check("stall_result", {res_class, res_tag, res_timeout}, cap);
    check("stall_no_issue", issue_cnt, n_issue);
    check("stall_queued", fifo_count, 32'd1);
    rr_fixed = 1'b1;
    wait_drain(300);

    // Six back-to-back pushes with a slow classifier fill the FIFO.
    cls_lat = 6;
    rel_lat = 0;
    for (int i = 0; i < 6; i++) push_query(W'($urandom), DW'($urandom_range(0, 9)));
    idle_in();
    wait_drain(500);

    // Random traffic, latencies and back-pressure.
    lat_random = 1'b1;
    rr_random  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      push_query(W'($urandom), ($urandom_range(0, 3) == 0) ? DW'(0) : DW'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        idle_in();
        repeat ($urandom_range(0, 3)) tick();
      end
    end
    idle_in();
    rr_random = 1'b0;
    wait_drain(3000);
    lat_random = 1'b0;

    // Reset while waiting on the classifier with two entries queued.
    cls_lat = 40;
    push_query(16'h1122, 8'd1);
    push_query(16'h3344, 8'd2);
    push_query(16'h5566, 8'd0);
    idle_in();
    n = 0;
    while (res_q.size() == 0 && n < 100) begin
      tick();
      n++;
    end
    tick();
    check("mid_wait_start", knn_start, 1'b1);
    check("mid_wait_count", fifo_count, 32'd2);
    do_reset();
    cls_lat = 2;
    push_query(16'h0705, 8'd4);
    idle_in();
    wait_res_valid(200);
    check("fresh_tag", res_tag, 32'd0);
    check("fresh_class", res_class, 1'b1);
    wait_drain(100);

    // Hung classifier: watchdog result, then halt with entries retained.
    hang_mode = 1'b1;
    push_query(16'h0102, 8'd3);
    push_query(16'h0304, 8'd3);
    push_query(16'h0506, 8'd3);
    idle_in();
    wait_res_valid(200);
    check("wd_timeout", res_timeout, 1'b1);
    check("wd_class", res_class, 1'b0);
    tick();
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'hABCD;
    in_k     = 8'd2;
    #4;
    repeat (10) tick();
    check("halt_in_ready", in_ready, 1'b0);
    check("halt_count", fifo_count, 32'd2);
    check("halt_busy", busy, 1'b1);
    check("halt_start", knn_start, 1'b0);
    check("halt_res_valid", res_valid, 1'b0);
    idle_in();
    hang_mode = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    tests_failed++;
    $display("FAIL global_timeout: simulation did not complete, got t=%0t expected earlier", $time);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
